// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer line reader.
// Holds the FSM state encoding, the pixel and burst geometry constants,
// and the default LCD panel geometry used as top-level parameter defaults.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DONE      = 2'd3
  } fb_state_e;

  localparam int PIX_WIDTH    = 16;  // RGB565
  localparam int BURST_PIXELS = 4;   // pixels per 64-bit SDRAM read
  localparam int BURST_WIDTH  = PIX_WIDTH * BURST_PIXELS;

  localparam int LCD_H_PIXELS = 480;
  localparam int LCD_V_LINES  = 272;

endpackage

// File: rtl/fb_pixel_fifo.sv
// Pixel FIFO: accepts one 64-bit burst (four RGB565 pixels) per write and
// delivers one 16-bit pixel per read. Pixel [15:0] of a burst leaves first.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset (empties the FIFO)
//   flush_i     - empties the FIFO; wins over a simultaneous write or read
//   wr_en_i     - write the four pixels of wr_data_i
//   wr_data_i   - 64-bit burst
//   rd_en_i     - pop the head pixel (ignored while empty)
//   rd_data_o   - head pixel, forced to 0 while empty
//   count_o     - number of stored pixels
//   empty_o     - FIFO holds no pixels
module fb_pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          wr_en_i,
  input  logic [BURST_WIDTH-1:0]        wr_data_i,
  input  logic                          rd_en_i,
  output logic [PIX_WIDTH-1:0]          rd_data_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PIX_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !flush_i;
  assign do_rd = rd_en_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(BURST_PIXELS);
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CNT_W'(BURST_PIXELS);
        2'b01:   count_d = count_q - CNT_W'(1);
        2'b11:   count_d = count_q + CNT_W'(BURST_PIXELS - 1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; count_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < BURST_PIXELS; i++) begin
        mem_q[wr_ptr_q + PTR_W'(i)] <= wr_data_i[i*PIX_WIDTH +: PIX_WIDTH];
      end
    end
  end

endmodule

// File: rtl/fb_line_reader.sv
// Framebuffer line reader: walks the framebuffer in SDRAM one 4-pixel burst
// at a time, keeps a small pixel FIFO topped up, and streams RGB565 pixels
// to the LCD timing stage with a valid/ready handshake.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   frame_start     - pulse: flush, rewind to FB_BASE, resume fetching
//   sd_rd_addr      - SDRAM read word address (held while requesting)
//   sd_rd_enable    - SDRAM read request, held until sd_busy is seen
//   sd_busy         - controller has taken the request
//   sd_rd_ready     - pulse marking sd_rd_data valid
//   sd_rd_data      - 64-bit burst, pixel [15:0] first
//   pix_data        - RGB565 FIFO head (0 when empty)
//   pix_valid       - FIFO not empty
//   pix_ready       - consumer takes the head pixel
//   underrun        - pulse: consumer ready, FIFO empty, frame still active
//   underrun_cnt    - saturating underrun counter, present only when
//                     FB_LINE_READER_UNDERRUN_CNT_EN is defined
module fb_line_reader
  import fb_pkg::*;
#(
  parameter int          HADDR_WIDTH = 23,
  parameter int unsigned FB_BASE     = 0,
  parameter int          H_PIXELS    = LCD_H_PIXELS,
  parameter int          V_LINES     = LCD_V_LINES,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  output logic [HADDR_WIDTH-1:0] sd_rd_addr,
  output logic                   sd_rd_enable,
  input  logic                   sd_busy,
  input  logic                   sd_rd_ready,
  input  logic [BURST_WIDTH-1:0] sd_rd_data,
  output logic [PIX_WIDTH-1:0]   pix_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   underrun
`ifdef FB_LINE_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_cnt
`endif
);

  localparam int BURSTS  = (H_PIXELS * V_LINES) / BURST_PIXELS;
  localparam int BURST_W = $clog2(BURSTS + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HADDR_WIDTH-1:0] BASE_ADDR  = HADDR_WIDTH'(FB_BASE);
  localparam logic [CNT_W-1:0]       REQ_LIMIT  = CNT_W'(FIFO_DEPTH - BURST_PIXELS);
  localparam logic [BURST_W-1:0]     LAST_BURST = BURST_W'(BURSTS - 1);

  fb_state_e              state_q, state_d;
  logic [HADDR_WIDTH-1:0] addr_q, addr_d;          // next burst to fetch
  logic [HADDR_WIDTH-1:0] req_addr_q, req_addr_d;  // address on the bus
  logic [BURST_W-1:0]     burst_q, burst_d;
  logic                   discard_q, discard_d;    // drop the in-flight burst

  logic                   fifo_wr, fifo_pop, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   room_for_burst;

  assign room_for_burst = (fifo_count <= REQ_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DONE;
      addr_q     <= BASE_ADDR;
      req_addr_q <= BASE_ADDR;
      burst_q    <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_addr_q <= req_addr_d;
      burst_q    <= burst_d;
      discard_q  <= discard_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_addr_d = req_addr_q;
    burst_d    = burst_q;
    discard_d  = discard_q;

    // A restart always rewinds the fetch pointer; what happens to a request
    // already on the bus depends on the state below.
    if (frame_start) begin
      addr_d  = BASE_ADDR;
      burst_d = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!frame_start && room_for_burst) begin
          state_d    = ST_REQ;
          req_addr_d = addr_q;
        end
      end
      ST_REQ: begin
        // The controller may already be committed to this read, so the
        // request is held until it is taken and its data is dropped later.
        if (frame_start) discard_d = 1'b1;
        if (sd_busy)     state_d   = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (sd_rd_ready) begin
          discard_d = 1'b0;
          if (frame_start || discard_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + HADDR_WIDTH'(BURST_PIXELS);
            burst_d = burst_q + BURST_W'(1);
            state_d = (burst_q == LAST_BURST) ? ST_DONE : ST_IDLE;
          end
        end else if (frame_start) begin
          discard_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (frame_start) state_d = ST_IDLE;
      end
      default: state_d = ST_DONE;
    endcase
  end

  // Output logic
  always_comb begin
    sd_rd_enable = (state_q == ST_REQ);
    fifo_wr      = (state_q == ST_WAIT_DATA) && sd_rd_ready && !frame_start && !discard_q;
    fifo_pop     = pix_valid && pix_ready;
    underrun     = pix_ready && fifo_empty && (state_q != ST_DONE);
  end

  assign sd_rd_addr = req_addr_q;
  assign pix_valid  = !fifo_empty;

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (frame_start),
    .wr_en_i   (fifo_wr),
    .wr_data_i (sd_rd_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (pix_data),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

`ifdef FB_LINE_READER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (frame_start)                          ucnt_d = '0;
    else if (underrun && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: doc/fb_line_reader.md
FB_LINE_READER -- requirements
Module: fb_line_reader

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- HADDR_WIDTH, 23, SDRAM host word address width.
- FB_BASE, 0, first word address of the framebuffer.
- H_PIXELS, 480, pixels per line.
- V_LINES, 272, lines per frame.
- FIFO_DEPTH, 16, pixel FIFO depth in 16-bit entries (power of 2, >= 8).

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- frame_start, in, 1, one-cycle pulse that restarts fetching at FB_BASE.
- sd_rd_addr, out, HADDR_WIDTH, read address to the SDRAM controller.
- sd_rd_enable, out, 1, read request.
- sd_busy, in, 1, controller busy.
- sd_rd_ready, in, 1, one-cycle pulse marking sd_rd_data valid.
- sd_rd_data, in, 64, burst of 4 pixels.
- pix_data, out, 16, RGB565 pixel to the LCD timing stage.
- pix_valid, out, 1, pix_data valid.
- pix_ready, in, 1, consumer accepts the pixel.
- underrun, out, 1, one-cycle pulse.

REQ-003 The design SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have the states IDLE, REQ, WAIT_DATA and DONE.
REQ-005 In IDLE, fetching is active, and FIFO free space >= 4, the FSM SHALL go to REQ.
REQ-006 In REQ, sd_rd_enable SHALL be 1 and sd_rd_addr SHALL be stable until sd_busy is sampled 1; the next cycle SHALL drop sd_rd_enable and enter WAIT_DATA.
REQ-007 In WAIT_DATA, on sd_rd_ready the 64-bit word SHALL be written to the FIFO in one cycle. Pixel order is [15:0], [31:16], [47:32], [63:48].
REQ-008 After each write, the burst counter and address SHALL advance: address += 4. After the burst index BURSTS-1 (BURSTS = H_PIXELS*V_LINES/4), the FSM SHALL enter DONE.
REQ-009 At most one request SHALL be outstanding at any time.
REQ-010 pix_valid SHALL equal FIFO not-empty, and pix_data SHALL be the FIFO head. A pop SHALL occur on pix_valid & pix_ready.
REQ-011 The FIFO SHALL never overflow: a request is issued only if count <= FIFO_DEPTH-4.
REQ-012 underrun SHALL pulse when pix_ready=1, the FIFO is empty, and the state is not DONE.
REQ-013 DONE SHALL stop requests. pix_valid SHALL drain the remaining pixels.
REQ-014 When frame_start arrives in IDLE, REQ or DONE:
- the FIFO SHALL be flushed;
- the address SHALL be set to FB_BASE and the burst count to 0;
- the FSM SHALL go to IDLE;
- a pending REQ SHALL be abandoned only after sd_busy has been seen, then handled as in REQ-015.
REQ-015 When frame_start arrives in WAIT_DATA:
- the FIFO SHALL be flushed and the address reset immediately;
- the in-flight burst SHALL be discarded on its sd_rd_ready;
- the FSM SHALL then enter IDLE.
REQ-016 When frame_start and sd_rd_ready coincide, the data SHALL be discarded and frame_start takes priority.
REQ-017 When a FIFO write and pop coincide, count SHALL equal count+4-1. FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-018 On rst the block SHALL drive:
- state = DONE;
- sd_rd_enable = 0;
- sd_rd_addr = FB_BASE;
- FIFO empty;
- pix_valid = 0;
- pix_data = 0;
- underrun = 0.
Fetching SHALL begin only after the first frame_start.
REQ-019 rst during a read SHALL be accepted. Data from a post-reset sd_rd_ready SHALL be ignored while in DONE.

Configuration
REQ-020 With FB_LINE_READER_UNDERRUN_CNT_EN defined, the block SHALL add the output port underrun_cnt (16 bits). It increments on each underrun, saturates at 0xFFFF, and clears on rst or frame_start.
REQ-021 Without FB_LINE_READER_UNDERRUN_CNT_EN, the underrun_cnt port and its logic SHALL be absent. The underrun pulse remains in both builds.

Structure
REQ-022 Package fb_pkg SHALL hold:
- the FSM state encoding;
- the PIX_WIDTH=16 and BURST_PIXELS=4 constants;
- the default LCD geometry.
REQ-023 The FIFO SHALL be the sub-module fb_pixel_fifo, with a 64-bit write, 16-bit read, and a count output.

Verification
REQ-024 Startup: rst, then frame_start, with pix_ready=0. The bench SHALL see requests at addresses 0, 4, 8 and 12, after which fetching stalls with the FIFO holding 16 pixels.
REQ-025 Order: return 0x4444_3333_2222_1111. pix_data SHALL be 0x1111, 0x2222, 0x3333, 0x4444 in that order.
REQ-026 Refresh stall: sd_busy stays low for 10 cycles after a request. sd_rd_enable and the address SHALL be held; exactly one burst SHALL be fetched.
REQ-027 End of frame: with H_PIXELS=8 and V_LINES=2, the last request SHALL go to address 12. The FSM then enters DONE, and the 16 pixels SHALL drain.
REQ-028 Restart: frame_start is asserted in WAIT_DATA. The next sd_rd_ready data SHALL be dropped, the FIFO SHALL be empty, and the next request SHALL go to FB_BASE.
REQ-029 Underrun: with pix_ready=1 and the FIFO empty while active, there SHALL be one underrun pulse per cycle. With the macro defined, underrun_cnt SHALL read 3 after 3 cycles.
